control_unit_legv8: RTL and testbench

Multi-cycle instruction decoder that sits directly upstream of the LEGv8 datapath-with-memory. It accepts 32-bit LEGv8 instructions over a valid/ready handshake and drives the datapath's 32-bit control word and 64-bit constant, one control word per cycle. Register/immediate ALU ops issue in one cycle. LDUR/STUR issue as a two-cycle sequence (address into scratch R7, then memory access).

---
 rtl/control_unit_legv8.sv | 159 +++++++++++++++
 tb/tb_control_unit_legv8.sv | 138 +++++++++++++
 2 files changed

// File: rtl/control_unit_legv8.sv
// LEGv8 instruction decoder: turns accepted instructions into datapath control
// words, issuing ALU ops in one cycle and LDUR/STUR as an address/access pair.
module control_unit_legv8 #(
    parameter logic [4:0] SCRATCH_REG = 5'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [31:0] control_word,
    output logic [63:0] constant,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {IDLE, ISSUE, MEM_ADDR, MEM_ACC} state_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] XZR    = 5'd31;

    // Pack datapath control fields into the 32-bit word; C0 and [31:27] are unused.
    function automatic logic [31:0] make_word(
        input logic       ds,
        input logic       as_,
        input logic       mr,
        input logic       mw,
        input logic [4:0] fs,
        input logic       bs,
        input logic       rw,
        input logic [4:0] sb,
        input logic [4:0] sa,
        input logic [4:0] da
    );
        make_word = {5'b00000, ds, as_, mr, mw, 1'b0, fs, bs, rw, sb, sa, da};
    endfunction

    state_t      state_r;
    logic [4:0]  rt_r;
    logic        load_r;

    logic        is_alu_s;
    logic        is_mem_s;
    logic        is_load_s;
    logic        bs_s;
    logic [4:0]  fs_s;
    logic [4:0]  rd_s;
    logic [4:0]  rn_s;
    logic [4:0]  rm_s;
    logic        accept_s;
    logic [31:0] alu_word_s;
    logic [63:0] alu_const_s;
    logic [31:0] addr_word_s;
    logic [63:0] addr_const_s;
    logic [31:0] acc_word_s;

    assign rd_s        = instr[4:0];
    assign rn_s        = instr[9:5];
    assign rm_s        = instr[20:16];
    assign instr_ready = reset & (state_r != MEM_ADDR);
    assign accept_s    = instr_valid & instr_ready;

    // Opcode decode: R-type and D-type use 11 opcode bits, I-type uses 10.
    always_comb begin
        is_alu_s  = 1'b0;
        is_mem_s  = 1'b0;
        is_load_s = 1'b0;
        bs_s      = 1'b0;
        fs_s      = FS_AND;
        case (instr[31:21])
            11'b10001011000: begin is_alu_s = 1'b1; fs_s = FS_ADD; end
            11'b11001011000: begin is_alu_s = 1'b1; fs_s = FS_SUB; end
            11'b10001010000: begin is_alu_s = 1'b1; fs_s = FS_AND; end
            11'b10101010000: begin is_alu_s = 1'b1; fs_s = FS_ORR; end
            11'b11111000010: begin is_mem_s = 1'b1; is_load_s = 1'b1; end
            11'b11111000000: begin is_mem_s = 1'b1; end
            default: begin
                case (instr[31:22])
                    10'b1001000100: begin is_alu_s = 1'b1; bs_s = 1'b1; fs_s = FS_ADD; end
                    10'b1101000100: begin is_alu_s = 1'b1; bs_s = 1'b1; fs_s = FS_SUB; end
                    10'b1001001000: begin is_alu_s = 1'b1; bs_s = 1'b1; fs_s = FS_AND; end
                    10'b1011001000: begin is_alu_s = 1'b1; bs_s = 1'b1; fs_s = FS_ORR; end
                    default:        begin is_alu_s = 1'b0; end
                endcase
            end
        endcase
    end

    // Candidate words for each issue slot; writes to XZR are suppressed via RW.
    always_comb begin
        alu_word_s   = make_word(1'b0, 1'b0, 1'b0, 1'b0, fs_s, bs_s, (rd_s != XZR),
                                 bs_s ? 5'd0 : rm_s, rn_s, rd_s);
        alu_const_s  = bs_s ? {52'd0, instr[21:10]} : 64'd0;
        addr_word_s  = make_word(1'b0, 1'b0, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b1,
                                 5'd0, rn_s, SCRATCH_REG);
        addr_const_s = {{55{instr[20]}}, instr[20:12]};
        if (load_r) begin
            acc_word_s = make_word(1'b1, 1'b1, 1'b1, 1'b0, FS_AND, 1'b0, (rt_r != XZR),
                                   5'd0, SCRATCH_REG, rt_r);
        end else begin
            acc_word_s = make_word(1'b0, 1'b1, 1'b0, 1'b1, FS_AND, 1'b0, 1'b0,
                                   rt_r, SCRATCH_REG, 5'd0);
        end
    end

    // Issue FSM with registered control word, constant, sticky illegal and retire count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            control_word <= 32'd0;
            constant     <= 64'd0;
            illegal      <= 1'b0;
            retired      <= 16'd0;
            rt_r         <= 5'd0;
            load_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ISSUE, MEM_ACC: begin
                    if (!accept_s) begin
                        state_r      <= IDLE;
                        control_word <= 32'd0;
                        constant     <= 64'd0;
                    end else if (is_mem_s) begin
                        state_r      <= MEM_ADDR;
                        control_word <= addr_word_s;
                        constant     <= addr_const_s;
                        rt_r         <= rd_s;
                        load_r       <= is_load_s;
                    end else if (is_alu_s) begin
                        state_r      <= ISSUE;
                        control_word <= alu_word_s;
                        constant     <= alu_const_s;
                        retired      <= retired + 16'd1;
                    end else begin
                        state_r      <= ISSUE;
                        control_word <= 32'd0;
                        constant     <= 64'd0;
                        illegal      <= 1'b1;
                    end
                end
                MEM_ADDR: begin
                    state_r      <= MEM_ACC;
                    control_word <= acc_word_s;
                    constant     <= 64'd0;
                    retired      <= retired + 16'd1;
                end
                default: begin
                    state_r      <= IDLE;
                    control_word <= 32'd0;
                    constant     <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Vector table plus scoreboard queue for control_unit_legv8, with a reset-during-MEM_ADDR sequence.
module tb_control_unit_legv8;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] control_word;
    logic [63:0] constant;
    logic        illegal;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        ready;
        logic [31:0] cw;
        logic [63:0] cst;
        logic        ill;
        logic [15:0] ret;
    } vec_t;

    typedef struct {
        logic [31:0] cw;
        logic [63:0] cst;
        logic        ill;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[18];

    control_unit_legv8 dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .control_word (control_word),
        .constant     (constant),
        .illegal      (illegal),
        .retired      (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        instr       = v.instr;
        instr_valid = v.valid;
        #1;
        chk($sformatf("v%0d.ready", idx), {63'd0, instr_ready}, {63'd0, v.ready});
        sb_q.push_back('{v.cw, v.cst, v.ill, v.ret});
        @(posedge clock);
        @(negedge clock);
        if (sb_q.size() == 0) begin
            chk($sformatf("v%0d.queue", idx), 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d.cw", idx),  {32'd0, control_word}, {32'd0, e.cw});
            chk($sformatf("v%0d.cst", idx), constant, e.cst);
            chk($sformatf("v%0d.ill", idx), {63'd0, illegal}, {63'd0, e.ill});
            chk($sformatf("v%0d.ret", idx), {48'd0, retired}, {48'd0, e.ret});
        end
    endtask

    initial begin
        tbl[0]  = '{32'h910063E0, 1'b1, 1'b1, 32'h001183E0, 64'd24, 1'b0, 16'd1};
        tbl[1]  = '{32'hCB0003E1, 1'b1, 1'b1, 32'h001283E1, 64'd0, 1'b0, 16'd2};
        tbl[2]  = '{32'hF80083E1, 1'b1, 1'b1, 32'h001183E7, 64'd8, 1'b0, 16'd2};
        tbl[3]  = '{32'hF80083E1, 1'b1, 1'b0, 32'h028004E0, 64'd0, 1'b0, 16'd3};
        tbl[4]  = '{32'hF85F83E2, 1'b1, 1'b1, 32'h001183E7, 64'hFFFFFFFFFFFFFFF8, 1'b0, 16'd3};
        tbl[5]  = '{32'h00000000, 1'b0, 1'b0, 32'h070080E2, 64'd0, 1'b0, 16'd4};
        tbl[6]  = '{32'h8B020023, 1'b0, 1'b1, 32'h00000000, 64'd0, 1'b0, 16'd4};
        tbl[7]  = '{32'h8B020023, 1'b1, 1'b1, 32'h00108823, 64'd0, 1'b0, 16'd5};
        tbl[8]  = '{32'h8A020024, 1'b1, 1'b1, 32'h00008824, 64'd0, 1'b0, 16'd6};
        tbl[9]  = '{32'hAA020025, 1'b1, 1'b1, 32'h00088825, 64'd0, 1'b0, 16'd7};
        tbl[10] = '{32'hD13FFC26, 1'b1, 1'b1, 32'h00138026, 64'h0000000000000FFF, 1'b0, 16'd8};
        tbl[11] = '{32'h9200143F, 1'b1, 1'b1, 32'h0001003F, 64'd5, 1'b0, 16'd9};
        tbl[12] = '{32'hB2000447, 1'b1, 1'b1, 32'h00098047, 64'd1, 1'b0, 16'd10};
        tbl[13] = '{32'h00000000, 1'b1, 1'b1, 32'h00000000, 64'd0, 1'b1, 16'd10};
        tbl[14] = '{32'h910063E0, 1'b1, 1'b1, 32'h001183E0, 64'd24, 1'b1, 16'd11};
        tbl[15] = '{32'hF84FF03F, 1'b1, 1'b1, 32'h00118027, 64'd255, 1'b1, 16'd11};
        tbl[16] = '{32'h00000000, 1'b0, 1'b0, 32'h070000FF, 64'd0, 1'b1, 16'd12};
        tbl[17] = '{32'h00000000, 1'b0, 1'b1, 32'h00000000, 64'd0, 1'b1, 16'd12};

        reset       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.cw",    {32'd0, control_word}, 64'd0);
        chk("rst.cst",   constant, 64'd0);
        chk("rst.ill",   {63'd0, illegal}, 64'd0);
        chk("rst.ret",   {48'd0, retired}, 64'd0);
        chk("rst.ready", {63'd0, instr_ready}, 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(i, tbl[i]);
        end

        // Reset in the middle of an LDUR: the access cycle must be abandoned.
        step(100, '{32'hF85F83E2, 1'b1, 1'b1, 32'h001183E7, 64'hFFFFFFFFFFFFFFF8, 1'b1, 16'd12});
        chk("mid.ready_low", {63'd0, instr_ready}, 64'd0);
        instr_valid = 1'b0;
        reset       = 1'b0;
        #1;
        chk("mid.cw",    {32'd0, control_word}, 64'd0);
        chk("mid.cst",   constant, 64'd0);
        chk("mid.ready", {63'd0, instr_ready}, 64'd0);
        chk("mid.ill",   {63'd0, illegal}, 64'd0);
        chk("mid.ret",   {48'd0, retired}, 64'd0);
        @(negedge clock);
        chk("mid.hold_cw", {32'd0, control_word}, 64'd0);
        reset = 1'b1;
        step(101, '{32'h00000000, 1'b0, 1'b1, 32'h00000000, 64'd0, 1'b0, 16'd0});
        step(102, '{32'h8B020023, 1'b1, 1'b1, 32'h00108823, 64'd0, 1'b0, 16'd1});
        step(103, '{32'h00000000, 1'b0, 1'b1, 32'h00000000, 64'd0, 1'b0, 16'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
